// File: rtl/rand_arbiter_pkg.sv
// Shared constants and types for the round-robin random word server.
package rand_arbiter_pkg;

    localparam int          LFSR_W       = 64;
    localparam logic [63:0] LFSR_POLY    = 64'h1B;
    localparam logic [63:0] DEFAULT_SEED = 64'h0c45f864_04e4684a;

    typedef enum logic [1:0] {LOAD, WARM, RUN} rand_arb_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], 1'b0} ^ ({LFSR_W{s[LFSR_W-1]}} & LFSR_POLY);
    endfunction

endpackage

// File: rtl/rand_lfsr64.sv
// 64-bit Galois LFSR; load wins over advance, otherwise the state holds.
module rand_lfsr64
    import rand_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (adv) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DEFAULT_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin front end time-sharing one LFSR among NUM_REQ requesters.
// Define RAND_ARBITER_STATS_EN to add per-requester saturating grant counters.
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int WARMUP  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               seed_load,
    input  logic [63:0]        seed_val,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               busy
`ifdef RAND_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] grant_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);

    rand_arb_state_t    state_q, state_d;
    logic [7:0]         warm_cnt_q, warm_cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [63:0]        seed_q, seed_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               busy_q, busy_d;

    logic               lfsr_load, lfsr_adv;
    logic [63:0]        lfsr_state;
    logic               lfsr_unused;

    logic [PTR_W-1:0]   winner;
    logic               any_req;

    rand_lfsr64 u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (lfsr_load),
        .load_val (seed_q),
        .adv      (lfsr_adv),
        .state    (lfsr_state)
    );

    // Only the low WIDTH bits leave the block; the rest is internal state.
    assign lfsr_unused = ^lfsr_state;

    always_comb begin
        logic [PTR_W-1:0] cand;
        winner  = rr_ptr_q;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        warm_cnt_d  = warm_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        seed_d      = seed_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;
        if (seed_load) begin
            // Reseed pre-empts any grant; the seed is captured now, applied in LOAD.
            state_d = LOAD;
            seed_d  = (seed_val == 64'd0) ? DEFAULT_SEED : seed_val;
        end else begin
            case (state_q)
                LOAD: begin
                    lfsr_load  = 1'b1;
                    warm_cnt_d = '0;
                    state_d    = WARM;
                end
                WARM: begin
                    lfsr_adv   = 1'b1;
                    warm_cnt_d = warm_cnt_q + 8'd1;
                    if (warm_cnt_q == 8'(WARMUP - 1)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (any_req) begin
                        rsp_valid_d[winner] = 1'b1;
                        rsp_data_d          = lfsr_state[WIDTH-1:0];
                        lfsr_adv            = 1'b1;
                        rr_ptr_d            = winner;
                    end
                end
                default: state_d = WARM;
            endcase
        end
        busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WARM;
            warm_cnt_q  <= '0;
            rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
            seed_q      <= DEFAULT_SEED;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            warm_cnt_q  <= warm_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            seed_q      <= seed_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

`ifdef RAND_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_q, grant_d;

    always_comb begin
        grant_d = grant_q;
        if (seed_load) begin
            grant_d = '0;
        end else if (state_q == RUN && any_req && grant_q[winner] != 16'hFFFF) begin
            grant_d[winner] = grant_q[winner] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= '0;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign grant_cnt = grant_q;
`endif

endmodule

// File: tb/tb_rand_arbiter.sv
// Scoreboard bench for rand_arbiter (default parameters: 4 requesters, 32-bit words).
module tb_rand_arbiter;

    localparam logic [63:0] DEF_SEED = 64'h0c45f864_04e4684a;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        seed_load = 1'b0;
    logic [63:0] seed_val = '0;
    logic [3:0]  req = '0;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
`ifdef RAND_ARBITER_STATS_EN
    logic [63:0] grant_cnt;
`endif

    rand_arbiter #(.NUM_REQ(4), .WIDTH(32), .WARMUP(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .req       (req),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef RAND_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  v;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [63:0] m_lfsr;
    int          m_ptr;
    logic [31:0] last_word;

    function automatic logic [63:0] m_step(input logic [63:0] s);
        logic [63:0] n;
        n = {s[62:0], 1'b0};
        if (s[63]) n = n ^ 64'h1B;
        return n;
    endfunction

    function automatic logic [63:0] m_steps(input logic [63:0] s, input int k);
        logic [63:0] r;
        r = s;
        for (int i = 0; i < k; i++) r = m_step(r);
        return r;
    endfunction

    task automatic push_grant(input int who);
        exp_t x;
        x.v = 4'(1 << who);
        x.d = m_lfsr[31:0];
        sb.push_back(x);
        last_word = m_lfsr[31:0];
        m_lfsr = m_step(m_lfsr);
        m_ptr = who;
    endtask

    task automatic push_idle();
        exp_t x;
        x.v = 4'b0000;
        x.d = last_word;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req = 4'b0001;
        repeat (2) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0000", rsp_valid);
        end
        n_checks++;
        if (rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00000000", rsp_data);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", busy);
        end
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
                n_fail++;
                $display("FAIL warmup_cycle%0d: busy=%b valid=%b expected busy=1 valid=0000", i, busy, rsp_valid);
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL warmup_end: busy=%b valid=%b expected busy=0 valid=0000", busy, rsp_valid);
        end
        m_lfsr = m_steps(DEF_SEED, 16);
        m_ptr = 3;
        last_word = '0;
    endtask

    task automatic test_round_robin();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_grant((m_ptr + 1) % 4);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (rsp_valid !== e.v || rsp_data !== e.d) begin
                n_fail++;
                $display("FAIL rr_all%0d: valid=%b data=%h expected valid=%b data=%h", k, rsp_valid, rsp_data, e.v, e.d);
            end
        end
    endtask

    task automatic test_single();
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            push_grant(0);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (rsp_valid !== e.v || rsp_data !== e.d) begin
                n_fail++;
                $display("FAIL single%0d: valid=%b data=%h expected valid=%b data=%h", k, rsp_valid, rsp_data, e.v, e.d);
            end
        end
    endtask

    task automatic test_alternate();
        req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            push_grant((m_ptr == 0 || m_ptr == 1) ? 2 : 0);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (rsp_valid !== e.v || rsp_data !== e.d) begin
                n_fail++;
                $display("FAIL alt%0d: valid=%b data=%h expected valid=%b data=%h", k, rsp_valid, rsp_data, e.v, e.d);
            end
        end
    endtask

    task automatic test_idle();
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            push_idle();
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (rsp_valid !== e.v || rsp_data !== e.d) begin
                n_fail++;
                $display("FAIL idle%0d: valid=%b data=%h expected valid=%b data=%h", k, rsp_valid, rsp_data, e.v, e.d);
            end
        end
        req = 4'b1000;
        push_grant(3);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (rsp_valid !== e.v || rsp_data !== e.d) begin
            n_fail++;
            $display("FAIL idle_resume: valid=%b data=%h expected valid=%b data=%h", rsp_valid, rsp_data, e.v, e.d);
        end
    endtask

    task automatic test_reseed(input logic [63:0] sv);
        seed_load = 1'b1;
        seed_val  = sv;
        req       = 4'b0010;
        @(negedge clk);
        seed_load = 1'b0;
        seed_val  = 64'hdeadbeef_12345678;
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
                n_fail++;
                $display("FAIL reseed_%h_busy%0d: busy=%b valid=%b expected busy=1 valid=0000", sv, i, busy, rsp_valid);
            end
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL reseed_%h_end: busy=%b valid=%b expected busy=0 valid=0000", sv, busy, rsp_valid);
        end
        m_lfsr = m_steps((sv == 64'd0) ? DEF_SEED : sv, 16);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push_grant((m_ptr + 1) % 4);
            @(negedge clk);
            e = sb.pop_front();
            n_checks++;
            if (rsp_valid !== e.v || rsp_data !== e.d) begin
                n_fail++;
                $display("FAIL reseed_%h_word%0d: valid=%b data=%h expected valid=%b data=%h", sv, k, rsp_valid, rsp_data, e.v, e.d);
            end
        end
    endtask

    task automatic test_async_reset();
        req = 4'b1111;
        push_grant((m_ptr + 1) % 4);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_checks++;
        if (rsp_valid !== e.v || rsp_data !== e.d) begin
            n_fail++;
            $display("FAIL pre_reset_grant: valid=%b data=%h expected valid=%b data=%h", rsp_valid, rsp_data, e.v, e.d);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 32'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h busy=%b expected 0000 00000000 1", rsp_valid, rsp_data, busy);
        end
        req = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef RAND_ARBITER_STATS_EN
    task automatic test_stats();
        seed_load = 1'b1;
        seed_val  = 64'd0;
        @(negedge clk);
        seed_load = 1'b0;
        n_checks++;
        if (grant_cnt !== 64'd0) begin
            n_fail++;
            $display("FAIL stats_clear0: got %h expected 0", grant_cnt);
        end
        repeat (18) @(negedge clk);
        req = 4'b0001;
        repeat (70000) @(negedge clk);
        req = 4'b0000;
        n_checks++;
        if (grant_cnt[15:0] !== 16'hFFFF || grant_cnt[63:16] !== 48'd0) begin
            n_fail++;
            $display("FAIL stats_saturate: got %h expected 000000000000ffff", grant_cnt);
        end
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        n_checks++;
        if (grant_cnt !== 64'd0) begin
            n_fail++;
            $display("FAIL stats_clear1: got %h expected 0", grant_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_alternate();
        test_idle();
        test_reseed(64'd0);
        test_reseed(64'd1);
        test_async_reset();
`ifdef RAND_ARBITER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rand_arbiter.md
Name: rand_arbiter

Overview:
- Shared pseudo-random word server: one 64-bit Galois LFSR, time-shared among NUM_REQ requesters under round-robin arbitration.
- Sequences the LFSR through seed load, a warm-up period and normal service.
- The LFSR advances only when a word is consumed, so a given seed and request pattern always give the same streams.
- Sits between stimulus/traffic-generator blocks and the random source they would otherwise each instantiate.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- WIDTH, 32: returned word width, 1..64; the word is lfsr[WIDTH-1:0].
- WARMUP, 16: LFSR advances after seed load before service starts, 1..255.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- seed_load  in  1  single-cycle strobe to load seed_val.
- seed_val  in  64  new seed; zero is illegal and replaced by DEFAULT_SEED.
- req  in  NUM_REQ  level request per requester; one word per grant.
- rsp_valid  out  NUM_REQ  one-hot, registered; marks the winner's word.
- rsp_data  out  WIDTH  random word, qualified by rsp_valid.
- busy  out  1  high in LOAD or WARM (not serving).

Behaviour:
- LFSR step: next = {lfsr[62:0],1'b0} ^ ({64{lfsr[63]}} & LFSR_POLY), with LFSR_POLY = 64'h1B.
- States: LOAD, WARM, RUN.
- Reset (async, reset_n low):
  - state=WARM, lfsr=DEFAULT_SEED (64'h0c45f864_04e4684a), warm_cnt=0, rr_ptr=NUM_REQ-1.
  - rsp_valid=0, rsp_data=0, busy=1.
- LOAD (one cycle):
  - Entered from any state on seed_load=1.
  - The next edge writes lfsr=(seed_val==0 ? DEFAULT_SEED : seed_val), sets warm_cnt=0 and moves to WARM.
  - seed_val is sampled in the seed_load cycle.
- WARM:
  - LFSR advances every cycle; warm_cnt increments.
  - After WARMUP advances, go to RUN; busy drops the cycle RUN is entered.
  - Requests are ignored (not queued).
- RUN:
  - Each cycle with any req bit set: winner = first set bit searching from rr_ptr+1, wrapping modulo NUM_REQ.
  - Next edge: rsp_valid=onehot(winner), rsp_data=lfsr[WIDTH-1:0] (pre-advance value), lfsr advances, rr_ptr=winner.
  - Latency: req at cycle t, response at t+1.
  - A requester holding req continuously receives a word on each of its grants.
  - No req set: lfsr holds, rsp_valid=0, rsp_data holds its last value.
- seed_load priority:
  - seed_load overrides any same-cycle grant: no rsp_valid, lfsr not advanced, rr_ptr unchanged.
  - seed_load during WARM or LOAD restarts the load/warm-up.
- rr_ptr survives reseed; only reset returns it to NUM_REQ-1.
- reset_n assertion mid-operation: immediate clear to reset values, including rsp_valid.
- Words are never duplicated across requesters: exactly one advance per rsp_valid.

Optional Feature:
- Macro: RAND_ARBITER_STATS_EN.
- Defined:
  - Adds output grant_cnt, NUM_REQ*16 bits: per-requester 16-bit saturating grant counters (hold at 16'hFFFF).
  - Counters clear on reset and on seed_load.
  - Counters increment in the same edge as the rsp_valid bit.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package rand_arbiter_pkg:
  - LFSR_W=64, LFSR_POLY=64'h1B, DEFAULT_SEED.
  - typedef enum logic [1:0] {LOAD, WARM, RUN} rand_arb_state_t.
- Sub-module rand_lfsr64:
  - Inputs: clk, reset_n, load, load_val, adv.
  - Output: state; applies the step above.
  - load has priority over adv.
  - Reset value is DEFAULT_SEED.

Test Plan:
- Reset release, req=4'b0001 held:
  - busy=1 for exactly 16 cycles, no rsp_valid during that time.
  - First rsp_data equals model LFSR after 16 steps from DEFAULT_SEED, truncated to 32 bits.
  - Subsequent words follow the model one step per grant.
- req=4'b1111 held in RUN -> rsp_valid sequence 0001, 0010, 0100, 1000, 0001; all words distinct consecutive model states.
- req=4'b0101 held -> rsp_valid alternates 0001, 0100; requesters 1 and 3 never granted.
- seed_load with seed_val=0 -> word stream identical to post-reset stream. seed_load with seed_val=64'h1 -> after warm-up, first word equals model state 16 steps from 64'h1.
- seed_load in the same cycle as req=4'b0010 in RUN -> no rsp_valid next cycle; busy=1 for 17 cycles (LOAD + 16 WARM).
- With RAND_ARBITER_STATS_EN, req=4'b0001 held for 70000 grants -> grant_cnt[15:0]=16'hFFFF, others 0; seed_load clears all counters to 0.
